hps_mailbox_slave: RTL and testbench
====================================

HPS_MAILBOX_SLAVE -- requirements
Module: hps_mailbox_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entries per FIFO; power of two, 2..128.
REQ-002 SHALL have parameter DATA_W, default 32, width of the Avalon data bus and stream data.
REQ-003 SHALL have port clk_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have Avalon-MM responder ports, as seen from the HPS lightweight bridge initiator:
- avs_address, input, 2 bits.
- avs_read, input, 1 bit.
- avs_write, input, 1 bit.
- avs_writedata, input, DATA_W bits.
- avs_readdata, output, DATA_W bits.
- avs_readdatavalid, output, 1 bit.
REQ-006 SHALL have port irq, output, 1 bit: level interrupt to the HPS.
REQ-007 SHALL have HPS-to-fabric stream ports:
- tx_data, output, DATA_W bits.
- tx_valid, output, 1 bit.
- tx_ready, input, 1 bit.
REQ-008 SHALL have fabric-to-HPS stream ports:
- rx_data, input, DATA_W bits.
- rx_valid, input, 1 bit.
- rx_ready, output, 1 bit.

Function
REQ-009 SHALL decode the register map as follows:
- Address 0 DATA_TX: a write pushes avs_writedata into the TX FIFO; a read returns 0.
- Address 1 DATA_RX: a read pops the RX FIFO; a write is ignored.
- Address 2 STATUS: read; W1C on bits 4 and 5.
- Address 3 CONTROL: read/write.
REQ-010 SHALL define STATUS bits as follows:
- [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty.
- [4] overflow (sticky), [5] underflow (sticky).
- [15:8] tx_count, [23:16] rx_count.
- All other bits read 0.
REQ-011 SHALL define CONTROL bits as follows:
- [0] rx_irq_en, [1] err_irq_en.
- [2] tx_flush, self-clearing and reads 0.
- [3] rx_flush, self-clearing and reads 0.
REQ-012 SHALL assert avs_readdatavalid exactly one cycle after each cycle with avs_read=1, with avs_readdata registered; there is no waitrequest, and every access completes.
REQ-013 SHALL drive avs_readdata to 0 in every cycle where avs_readdatavalid=0.
REQ-014 SHALL sample a DATA_RX read at the same edge as the pop, and return the head entry before the pop.
REQ-015 SHALL, on a DATA_TX write while the TX FIFO is full, drop the data and set overflow; FIFO contents and count are unchanged.
REQ-016 SHALL, on a DATA_RX read while the RX FIFO is empty, return 0, set underflow, and leave the count unchanged.
REQ-017 SHALL drive tx_valid = ~tx_empty with tx_data = the TX FIFO head (show-ahead); a pop occurs on a cycle with tx_valid & tx_ready.
REQ-018 SHALL drive rx_ready = ~rx_full; a push occurs on a cycle with rx_valid & rx_ready.
REQ-019 SHALL, on simultaneous push and pop on a full FIFO, complete both and keep the count unchanged; on an empty FIFO, the push takes effect and the pop is a no-op.
REQ-020 SHALL wrap read and write pointers modulo DEPTH; count is log2(DEPTH)+1 bits, zero-extended into STATUS.
REQ-021 SHALL, on a flush, empty the selected FIFO in the cycle after the CONTROL write; a push or pop in the flush cycle is discarded and the flag is not set.
REQ-022 SHALL register irq as (rx_irq_en & ~rx_empty) | (err_irq_en & (overflow | underflow)), one cycle behind its inputs.
REQ-023 SHALL, if a STATUS W1C and a new error event occur in the same cycle, leave the bit set (set wins).

Reset
REQ-024 SHALL, while reset_reset=1, asynchronously hold:
- Both FIFOs empty, pointers and counts 0.
- overflow, underflow and CONTROL at 0.
- avs_readdata=0, avs_readdatavalid=0, irq=0, tx_valid=0.
- rx_ready=1.
REQ-025 SHALL drop a read in flight when reset asserts; no avs_readdatavalid is issued for it after reset releases.
REQ-026 SHALL not reset FIFO storage RAM contents.

Structure
REQ-027 SHALL place register address constants, STATUS/CONTROL bit indices, and the count-width function in shared package hps_mailbox_pkg.
REQ-028 SHALL implement each FIFO as one instance of sub-module sync_fifo (parameters DEPTH, DATA_W; ports push, pop, din, dout, full, empty, count, flush), instantiated twice.

Verification
REQ-029 SHALL cover: write 0xA5A5_0001..0xA5A5_0003 to DATA_TX with tx_ready=1 -> tx_data emits the same three words in order, and the TX FIFO ends empty.
REQ-030 SHALL cover: with tx_ready=0, write 17 words at DEPTH=16 -> tx_count=16, STATUS[4]=1, and word 17 never appears on tx_data.
REQ-031 SHALL cover: push 0x1234_5678 on rx_valid, then read DATA_RX -> avs_readdatavalid one cycle later with 0x1234_5678; a second read returns 0 and sets STATUS[5].
REQ-032 SHALL cover: CONTROL=0x1, then one rx push -> irq=1 two cycles after the push; after the DATA_RX read, irq=0.
REQ-033 SHALL cover: fill the RX FIFO to 16, then assert rx_valid and read DATA_RX in the same cycle -> the count stays 16 and rx_ready toggles correctly.
REQ-034 SHALL cover: assert reset_reset mid-read -> avs_readdatavalid=0 throughout, and STATUS reads 0x0000_000A after release.

Source files
------------

// File: rtl/hps_mailbox_pkg.sv
// Shared constants for the HPS mailbox: register map, STATUS/CONTROL bit
// positions and the FIFO occupancy-count width helper.
package hps_mailbox_pkg;

  localparam logic [1:0] ADDR_DATA_TX = 2'd0;
  localparam logic [1:0] ADDR_DATA_RX = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_CONTROL = 2'd3;

  localparam int unsigned ST_TX_FULL    = 0;
  localparam int unsigned ST_TX_EMPTY   = 1;
  localparam int unsigned ST_RX_FULL    = 2;
  localparam int unsigned ST_RX_EMPTY   = 3;
  localparam int unsigned ST_OVERFLOW   = 4;
  localparam int unsigned ST_UNDERFLOW  = 5;
  localparam int unsigned ST_TX_CNT_LSB = 8;
  localparam int unsigned ST_RX_CNT_LSB = 16;
  localparam int unsigned ST_CNT_W      = 8;

  localparam int unsigned CTL_RX_IRQ_EN  = 0;
  localparam int unsigned CTL_ERR_IRQ_EN = 1;
  localparam int unsigned CTL_TX_FLUSH   = 2;
  localparam int unsigned CTL_RX_FLUSH   = 3;

  // Occupancy counter must hold 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with registered full/empty flags and a
// synchronous flush that overrides any push or pop in the same cycle.
module sync_fifo
  import hps_mailbox_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  logic [DATA_W-1:0]         din,
  output logic [DATA_W-1:0]         dout,
  output logic                      full,
  output logic                      empty,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              do_push, do_pop;

  // A push into a full FIFO is accepted only when a pop frees a slot.
  always_comb begin
    do_pop   = pop & ~empty_q & ~flush;
    do_push  = push & ~flush & (~full_q | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/hps_mailbox_slave.sv
// Avalon-MM mailbox between the HPS lightweight bridge and fabric streams:
// a TX FIFO (HPS->fabric), an RX FIFO (fabric->HPS), status, control, irq.
module hps_mailbox_slave
  import hps_mailbox_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [1:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_readdatavalid,
  output logic              irq,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready
);

  localparam int unsigned CW = cnt_w(DEPTH);

  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0]     tx_count, rx_count;
  logic [DATA_W-1:0] tx_dout, rx_dout;
  logic              wr_tx, wr_st, wr_ctl, rd_rx, rx_push;
  logic [DATA_W-1:0] status_c, reg_rdata_c;

  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              rx_irq_en_q, rx_irq_en_d, err_irq_en_q, err_irq_en_d;
  logic              tx_flush_q, tx_flush_d, rx_flush_q, rx_flush_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              irq_q, irq_d;

  always_comb begin
    wr_tx   = avs_write & (avs_address == ADDR_DATA_TX);
    wr_st   = avs_write & (avs_address == ADDR_STATUS);
    wr_ctl  = avs_write & (avs_address == ADDR_CONTROL);
    rd_rx   = avs_read  & (avs_address == ADDR_DATA_RX);
    rx_push = rx_valid & ~rx_full;
  end

  sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_tx_fifo (
    .clk   (clk_clk),
    .rst   (reset_reset),
    .push  (wr_tx),
    .pop   (tx_ready),
    .flush (tx_flush_q),
    .din   (avs_writedata),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_rx_fifo (
    .clk   (clk_clk),
    .rst   (reset_reset),
    .push  (rx_push),
    .pop   (rd_rx),
    .flush (rx_flush_q),
    .din   (rx_data),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  always_comb begin
    status_c = '0;
    status_c[ST_TX_FULL]   = tx_full;
    status_c[ST_TX_EMPTY]  = tx_empty;
    status_c[ST_RX_FULL]   = rx_full;
    status_c[ST_RX_EMPTY]  = rx_empty;
    status_c[ST_OVERFLOW]  = ovf_q;
    status_c[ST_UNDERFLOW] = unf_q;
    status_c[ST_TX_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(tx_count);
    status_c[ST_RX_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(rx_count);
  end

  // Next-state for error flags, control, read response and irq.
  always_comb begin
    rx_irq_en_d  = rx_irq_en_q;
    err_irq_en_d = err_irq_en_q;
    reg_rdata_c  = '0;

    // Error flags: a new event in the same cycle as a W1C keeps the bit set.
    ovf_d = (ovf_q & ~(wr_st & avs_writedata[ST_OVERFLOW]))
          | (wr_tx & tx_full & ~tx_ready & ~tx_flush_q);
    unf_d = (unf_q & ~(wr_st & avs_writedata[ST_UNDERFLOW]))
          | (rd_rx & rx_empty & ~rx_flush_q);

    if (wr_ctl) begin
      rx_irq_en_d  = avs_writedata[CTL_RX_IRQ_EN];
      err_irq_en_d = avs_writedata[CTL_ERR_IRQ_EN];
    end
    tx_flush_d = wr_ctl & avs_writedata[CTL_TX_FLUSH];
    rx_flush_d = wr_ctl & avs_writedata[CTL_RX_FLUSH];

    case (avs_address)
      ADDR_DATA_RX: reg_rdata_c = rx_empty ? '0 : rx_dout;
      ADDR_STATUS:  reg_rdata_c = status_c;
      ADDR_CONTROL: begin
        reg_rdata_c[CTL_RX_IRQ_EN]  = rx_irq_en_q;
        reg_rdata_c[CTL_ERR_IRQ_EN] = err_irq_en_q;
      end
      default:      reg_rdata_c = '0;
    endcase

    rvalid_d = avs_read;
    rdata_d  = avs_read ? reg_rdata_c : '0;
    irq_d    = (rx_irq_en_q & ~rx_empty) | (err_irq_en_q & (ovf_q | unf_q));
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      rx_irq_en_q  <= 1'b0;
      err_irq_en_q <= 1'b0;
      tx_flush_q   <= 1'b0;
      rx_flush_q   <= 1'b0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
      rx_irq_en_q  <= rx_irq_en_d;
      err_irq_en_q <= err_irq_en_d;
      tx_flush_q   <= tx_flush_d;
      rx_flush_q   <= rx_flush_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
      irq_q        <= irq_d;
    end
  end

  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvalid_q;
  assign irq               = irq_q;
  assign tx_data           = tx_dout;
  assign tx_valid          = ~tx_empty;
  assign rx_ready          = ~rx_full;

endmodule

// File: tb/tb_hps_mailbox_slave.sv
// Directed bench for hps_mailbox_slave: a queue-based mailbox model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_hps_mailbox_slave;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned DATA_W = 32;

  logic              clk_clk = 1'b0;
  logic              reset_reset = 1'b0;
  logic [1:0]        avs_address = '0;
  logic              avs_read = 1'b0;
  logic              avs_write = 1'b0;
  logic [DATA_W-1:0] avs_writedata = '0;
  logic [DATA_W-1:0] avs_readdata;
  logic              avs_readdatavalid;
  logic              irq;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b0;
  logic [DATA_W-1:0] rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              rx_ready;

  hps_mailbox_slave #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk_clk           (clk_clk),
    .reset_reset       (reset_reset),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .irq               (irq),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .rx_ready          (rx_ready)
  );

  initial forever #5 clk_clk = ~clk_clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- mailbox model ----------------
  logic [31:0] m_txq[$];
  logic [31:0] m_rxq[$];
  bit          m_ovf, m_unf, m_rx_en, m_err_en, m_tx_fl, m_rx_fl, m_rdv, m_irq;
  logic [31:0] m_rd = '0;

  function automatic logic [31:0] m_status();
    return {8'd0, 8'(m_rxq.size()), 8'(m_txq.size()), 2'b00, m_unf, m_ovf,
            m_rxq.size() == 0, m_rxq.size() == DEPTH,
            m_txq.size() == 0, m_txq.size() == DEPTH};
  endfunction

  always @(posedge clk_clk or posedge reset_reset) begin : model
    bit          wr_tx, wr_st, wr_ctl, rd_rx, tx_pop, tx_push, rx_pop, rx_push;
    bit          ovf_set, unf_set, irq_n;
    logic [31:0] rd_val;
    if (reset_reset) begin
      m_txq.delete();
      m_rxq.delete();
      {m_ovf, m_unf, m_rx_en, m_err_en, m_tx_fl, m_rx_fl, m_rdv, m_irq} = '0;
      m_rd = '0;
    end else begin
      wr_tx  = avs_write && avs_address == 2'd0;
      wr_st  = avs_write && avs_address == 2'd2;
      wr_ctl = avs_write && avs_address == 2'd3;
      rd_rx  = avs_read  && avs_address == 2'd1;
      rd_val = '0;
      if (avs_read) begin
        case (avs_address)
          2'd1:    rd_val = (m_rxq.size() != 0) ? m_rxq[0] : 32'd0;
          2'd2:    rd_val = m_status();
          2'd3:    rd_val = {30'd0, m_err_en, m_rx_en};
          default: rd_val = '0;
        endcase
      end
      irq_n   = (m_rx_en && m_rxq.size() != 0) || (m_err_en && (m_ovf || m_unf));
      ovf_set = wr_tx && m_txq.size() == DEPTH && !tx_ready && !m_tx_fl;
      unf_set = rd_rx && m_rxq.size() == 0 && !m_rx_fl;
      if (m_tx_fl) m_txq.delete();
      else begin
        tx_pop  = tx_ready && m_txq.size() != 0;
        tx_push = wr_tx && (m_txq.size() < DEPTH || tx_pop);
        if (tx_pop)  void'(m_txq.pop_front());
        if (tx_push) m_txq.push_back(avs_writedata);
      end
      if (m_rx_fl) m_rxq.delete();
      else begin
        rx_push = rx_valid && m_rxq.size() < DEPTH;
        rx_pop  = rd_rx && m_rxq.size() != 0;
        if (rx_pop)  void'(m_rxq.pop_front());
        if (rx_push) m_rxq.push_back(rx_data);
      end
      m_ovf   = (m_ovf && !(wr_st && avs_writedata[4])) || ovf_set;
      m_unf   = (m_unf && !(wr_st && avs_writedata[5])) || unf_set;
      m_tx_fl = wr_ctl && avs_writedata[2];
      m_rx_fl = wr_ctl && avs_writedata[3];
      if (wr_ctl) begin
        m_rx_en  = avs_writedata[0];
        m_err_en = avs_writedata[1];
      end
      m_rdv = avs_read;
      m_rd  = rd_val;
      m_irq = irq_n;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk_clk) begin
    if (cmp_en) begin
      check("tx_valid", 32'(tx_valid), 32'(m_txq.size() != 0));
      if (m_txq.size() != 0) check("tx_data", tx_data, m_txq[0]);
      check("rx_ready", 32'(rx_ready), 32'(m_rxq.size() < DEPTH));
      check("irq", 32'(irq), 32'(m_irq));
      check("readdatavalid", 32'(avs_readdatavalid), 32'(m_rdv));
      check("readdata", avs_readdata, m_rd);
    end
  end

  // Words handed to the fabric on tx handshakes.
  logic [31:0] tx_seen[$];
  always @(negedge clk_clk) begin
    if (!reset_reset && tx_valid && tx_ready) tx_seen.push_back(tx_data);
  end

  task automatic cyc();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    cyc();
    avs_write     = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    avs_address = a;
    avs_read    = 1'b1;
    cyc();
    avs_read    = 1'b0;
    d           = avs_readdata;
  endtask

  logic [31:0] d;
  int          n17;

  initial begin
    #1 reset_reset = 1'b1;
    #1 cmp_en = 1'b1;
    repeat (2) @(negedge clk_clk);
    check("rst_rdv", 32'(avs_readdatavalid), 32'd0);
    check("rst_rdata", avs_readdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    @(posedge clk_clk);
    #1 reset_reset = 1'b0;
    cyc();
    rd(2'd2, d); check("status_after_reset", d, 32'h0000_000A);
    rd(2'd3, d); check("control_after_reset", d, 32'h0);

    // Three words stream straight out with tx_ready held high.
    tx_ready = 1'b1;
    wr(2'd0, 32'hA5A5_0001);
    wr(2'd0, 32'hA5A5_0002);
    wr(2'd0, 32'hA5A5_0003);
    repeat (3) cyc();
    check("tx3_count", 32'(tx_seen.size()), 32'd3);
    if (tx_seen.size() == 3) begin
      check("tx3_w0", tx_seen[0], 32'hA5A5_0001);
      check("tx3_w1", tx_seen[1], 32'hA5A5_0002);
      check("tx3_w2", tx_seen[2], 32'hA5A5_0003);
    end
    rd(2'd2, d); check("tx3_status", d, 32'h0000_000A);
    rd(2'd0, d); check("data_tx_reads_zero", d, 32'h0);

    // Overfill TX with the sink stalled: 17th word dropped, overflow set.
    tx_ready = 1'b0;
    tx_seen.delete();
    for (int i = 0; i < 17; i++) wr(2'd0, 32'hB000_0000 + 32'(i));
    rd(2'd2, d); check("ovf_status", d, 32'h0000_1019);
    wr(2'd2, 32'h0000_0010);
    rd(2'd2, d); check("ovf_w1c_status", d, 32'h0000_1009);
    tx_ready = 1'b1;
    repeat (20) cyc();
    tx_ready = 1'b0;
    check("ovf_drain_count", 32'(tx_seen.size()), 32'd16);
    if (tx_seen.size() == 16) begin
      check("ovf_first", tx_seen[0], 32'hB000_0000);
      check("ovf_last", tx_seen[15], 32'hB000_000F);
    end
    n17 = 0;
    foreach (tx_seen[i]) if (tx_seen[i] == 32'hB000_0010) n17++;
    check("ovf_word17_absent", 32'(n17), 32'd0);

    // RX single word, then underflow on an empty read.
    rx_data = 32'h1234_5678; rx_valid = 1'b1; cyc(); rx_valid = 1'b0;
    rd(2'd1, d); check("rx_word", d, 32'h1234_5678);
    rd(2'd1, d); check("rx_empty_read", d, 32'h0);
    rd(2'd2, d); check("unf_status", d, 32'h0000_002A);
    wr(2'd2, 32'h0000_0020);
    rd(2'd2, d); check("unf_w1c_status", d, 32'h0000_000A);

    // RX interrupt timing.
    wr(2'd3, 32'h1);
    rd(2'd3, d); check("control_rb", d, 32'h1);
    rx_data = 32'hCAFE_0001; rx_valid = 1'b1; cyc(); rx_valid = 1'b0;
    check("irq_push_plus1", 32'(irq), 32'd0);
    cyc();
    check("irq_push_plus2", 32'(irq), 32'd1);
    rd(2'd1, d); check("irq_rx_word", d, 32'hCAFE_0001);
    cyc();
    check("irq_after_read", 32'(irq), 32'd0);

    // Error interrupt from underflow, cleared by W1C.
    wr(2'd3, 32'h2);
    rd(2'd1, d); check("err_empty_read", d, 32'h0);
    cyc();
    check("irq_err_set", 32'(irq), 32'd1);
    wr(2'd2, 32'h0000_0020);
    cyc();
    check("irq_err_clr", 32'(irq), 32'd0);

    // TX flush; a write in the flush cycle is discarded.
    wr(2'd0, 32'h1); wr(2'd0, 32'h2); wr(2'd0, 32'h3);
    wr(2'd3, 32'h4);
    wr(2'd0, 32'hDEAD_0000);
    rd(2'd2, d); check("tx_flush_status", d, 32'h0000_000A);

    // RX flush; a push in the flush cycle is discarded.
    rx_valid = 1'b1; rx_data = 32'h77; cyc(); cyc(); rx_valid = 1'b0;
    wr(2'd3, 32'h8);
    rx_valid = 1'b1; rx_data = 32'h88; cyc(); rx_valid = 1'b0;
    rd(2'd2, d); check("rx_flush_status", d, 32'h0000_000A);

    // Full RX: read while rx_valid is held; push waits for the freed slot.
    rx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rx_data = 32'hC000_0000 + 32'(i);
      cyc();
    end
    check("rx_full_ready", 32'(rx_ready), 32'd0);
    rx_data = 32'hC000_00AA;
    avs_address = 2'd1; avs_read = 1'b1; cyc(); avs_read = 1'b0;
    check("rx_full_pop_data", avs_readdata, 32'hC000_0000);
    check("rx_ready_reopen", 32'(rx_ready), 32'd1);
    cyc();
    rx_valid = 1'b0;
    check("rx_ready_refull", 32'(rx_ready), 32'd0);
    rd(2'd2, d); check("rx_full_status", d, 32'h0010_0006);
    for (int i = 1; i < 16; i++) begin
      rd(2'd1, d); check("rx_drain", d, 32'hC000_0000 + 32'(i));
    end
    rd(2'd1, d); check("rx_drain_last", d, 32'hC000_00AA);
    rd(2'd2, d); check("rx_drained_status", d, 32'h0000_000A);

    // Reset asserted while a STATUS read is in flight.
    wr(2'd3, 32'h3);
    wr(2'd0, 32'h5555_0000);
    rx_valid = 1'b1; rx_data = 32'h66; cyc(); rx_valid = 1'b0;
    avs_address = 2'd2; avs_read = 1'b1;
    #2 reset_reset = 1'b1;
    #1 avs_read = 1'b0;
    check("midread_rdv", 32'(avs_readdatavalid), 32'd0);
    check("midread_tx_valid", 32'(tx_valid), 32'd0);
    repeat (2) cyc();
    reset_reset = 1'b0;
    cyc();
    check("post_reset_rdv", 32'(avs_readdatavalid), 32'd0);
    rd(2'd2, d); check("post_reset_status", d, 32'h0000_000A);
    rd(2'd3, d); check("post_reset_control", d, 32'h0);
    repeat (2) cyc();

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
